seg7_capture_decoder: RTL and testbench
=======================================

// Module: seg7_capture_decoder
// PURPOSE
//  Receive-side counterpart of the digit-to-7-segment encoder. Samples a
//  time-multiplexed 7-segment display bus, as driven to the board's displays,
//  and waits until the pattern on it is stable. It then decodes each digit
//  position back to a 4-bit hex value. Used for board self-check and for
//  loopback of the clock display into the test logic.
// PARAMETERS
//  NUM_DIGITS     4  number of multiplexed digit positions (1..8)
//  STABLE_CYCLES  4  identical consecutive synchronized samples needed to commit (>=2)
// PORTS
//  clk          in   1             system clock, all logic rising-edge
//  reset        in   1             synchronous, active-high
//  segIn        in   7             active-low segments: bit0 top, 1 upper-right, 2 lower-right,
//                                  3 bottom, 4 lower-left, 5 upper-left, 6 middle
//  selIn        in   NUM_DIGITS    active-high digit enable, one-hot when valid
//  clearErr     in   1             clears errFlag (1-cycle pulse)
//  digits       out  4*NUM_DIGITS  decoded hex value per position, pos i at [4i+3:4i]
//  digitValid   out  NUM_DIGITS    1 = position holds a decoded hex digit
//  digitBlank   out  NUM_DIGITS    1 = last commit for the position was all-off (7'b1111111)
//  updateStrobe out  1             1-cycle pulse on every commit
//  updateIdx    out  3             position index of the last commit
//  errFlag      out  1             sticky: a stable, non-decodable pattern was committed
// BEHAVIOUR
//  - Reset: digits=0, digitValid=0, digitBlank=0, updateStrobe=0, updateIdx=0, errFlag=0,
//    sync flops=all-off/none-selected, FSM=IDLE, counter=0. Reset wins over every other input.
//  - segIn/selIn pass through a 2-flop synchronizer. Sample s = {selSync, segSync}.
//  - Counter cnt (saturating) counts consecutive cycles with s equal to the previous s.
//    Any change in s loads cnt=1.
//  - FSM: IDLE  - selSync not exactly one-hot; nothing is committed.
//           COUNT - one-hot, cnt<STABLE_CYCLES; -> LOCKED on reaching STABLE_CYCLES (commit).
//           LOCKED- committed; stays until s changes -> COUNT (or IDLE if not one-hot).
//    Exactly one commit per stable period; holding a value never re-strobes.
//  - Latency: segIn/selIn change held constant -> updateStrobe high
//    STABLE_CYCLES+2 cycles later. Outputs update on the same edge as the strobe.
//  - Commit for position i (index of the set selSync bit):
//    * Pattern in the decode table: digits[i]=value, digitValid[i]=1, digitBlank[i]=0.
//    * 7'b1111111: digitValid[i]=0, digitBlank[i]=1, digits[i] unchanged.
//    * Any other pattern: digitValid[i]=0, digitBlank[i]=0, digits[i] unchanged, errFlag=1.
//  - Decode table (seg[6:0] -> hex):
//    1000000=0 1111001=1 0100100=2 0110000=3 0011001=4 0010010=5 0000010=6 1111000=7
//    0000000=8 0011000=9 0001000=A 0000011=b 1000110=C 0100001=d 0000110=E 0001110=F
//  - Other positions are never modified by a commit.
//  - errFlag: set on an invalid commit, cleared by clearErr. Set and clear in the same
//    cycle -> set wins.
//  - updateIdx holds its value between strobes. Width is 3 regardless of NUM_DIGITS.
//  - Multiple or zero sel bits, even when stable, never commit and never set errFlag.
// TESTING (NUM_DIGITS=4, STABLE_CYCLES=4)
//  1. Reset, then hold selIn=0001, segIn=0100100 -> updateStrobe at cycle 6 only;
//     digits[3:0]=2, digitValid=0001, updateIdx=0. Holding for 20 more cycles -> no further strobe.
//  2. Scan positions 0..3 with codes for 1,A,d,F, each held 8 cycles ->
//     digits=16'hFDA1, digitValid=1111, 4 strobes with updateIdx 0,1,2,3.
//  3. selIn=0010, segIn toggles every 3 cycles (glitching) -> no strobe. Then held ->
//     one strobe STABLE_CYCLES+2 cycles after the last toggle.
//  4. selIn=0100, segIn=0111111 (invalid) held -> errFlag=1, digitValid[2]=0, digits[11:8]
//     unchanged. clearErr together with a new invalid commit -> errFlag stays 1.
//  5. selIn=1000, segIn=1111111 -> digitBlank[3]=1, digitValid[3]=0. selIn=0011 held ->
//     no strobe, no error.
//  6. Reset asserted during COUNT (cycle 3 of step 1) -> all outputs 0, no strobe.
//     Strobe comes 6 cycles after reset release.

Source files
------------

// File: rtl/seg7_capture_decoder.sv
// seg7_capture_decoder
//
// Receive side of the digit-to-7-segment encoder. Watches a time-multiplexed
// 7-segment display bus, waits until the {select, segments} pattern has been
// stable for STABLE_CYCLES synchronized samples, and then decodes the selected
// position back to a 4-bit hex value. Used for board self-check and for
// looping the clock display back into the test logic.
//
// Parameters
//   NUM_DIGITS     number of multiplexed digit positions (1..8)
//   STABLE_CYCLES  identical consecutive synchronized samples needed to commit (>=2)
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         synchronous, active-high; overrides every other input
//   segIn         active-low segments: bit0 top, 1 upper-right, 2 lower-right,
//                 3 bottom, 4 lower-left, 5 upper-left, 6 middle
//   selIn         active-high digit enables, one-hot when valid
//   clearErr      1-cycle pulse that clears errFlag
//   digits        decoded hex value per position, position i at [4i+3:4i]
//   digitValid    1 = position holds a decoded hex digit
//   digitBlank    1 = last commit for the position was all segments off
//   updateStrobe  1-cycle pulse on every commit
//   updateIdx     position index of the last commit (holds between strobes)
//   errFlag       sticky: a stable but non-decodable pattern was committed

module seg7_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segIn,
  input  logic [NUM_DIGITS-1:0]   selIn,
  input  logic                    clearErr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic [NUM_DIGITS-1:0]   digitBlank,
  output logic                    updateStrobe,
  output logic [2:0]              updateIdx,
  output logic                    errFlag
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TARGET = CW'(STABLE_CYCLES);
  localparam logic [6:0] SEG_ALL_OFF = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [6:0]              segMeta_q, segSync_q;
  logic [NUM_DIGITS-1:0]   selMeta_q, selSync_q;
  logic [NUM_DIGITS+6:0]   samplePrev_q;
  logic [CW-1:0]           cnt_q;
  state_t                  state_q;

  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   digitValid_q;
  logic [NUM_DIGITS-1:0]   digitBlank_q;
  logic                    updateStrobe_q;
  logic [2:0]              updateIdx_q;
  logic                    errFlag_q;

  logic [NUM_DIGITS+6:0]   sample;
  logic                    sampleChanged;
  logic [CW-1:0]           cnt_d;
  logic                    selOneHot;
  logic [2:0]              selIdx;
  logic [4:0]              decoded;

  // Map an active-low segment pattern to {valid, hex value}.
  function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
    case (seg)
      7'b1000000: decodeSeg = {1'b1, 4'h0};
      7'b1111001: decodeSeg = {1'b1, 4'h1};
      7'b0100100: decodeSeg = {1'b1, 4'h2};
      7'b0110000: decodeSeg = {1'b1, 4'h3};
      7'b0011001: decodeSeg = {1'b1, 4'h4};
      7'b0010010: decodeSeg = {1'b1, 4'h5};
      7'b0000010: decodeSeg = {1'b1, 4'h6};
      7'b1111000: decodeSeg = {1'b1, 4'h7};
      7'b0000000: decodeSeg = {1'b1, 4'h8};
      7'b0011000: decodeSeg = {1'b1, 4'h9};
      7'b0001000: decodeSeg = {1'b1, 4'hA};
      7'b0000011: decodeSeg = {1'b1, 4'hB};
      7'b1000110: decodeSeg = {1'b1, 4'hC};
      7'b0100001: decodeSeg = {1'b1, 4'hD};
      7'b0000110: decodeSeg = {1'b1, 4'hE};
      7'b0001110: decodeSeg = {1'b1, 4'hF};
      default:    decodeSeg = 5'b0;
    endcase
  endfunction

  // Two-flop synchronizer; reset parks the bus at "all segments off, nothing selected".
  always_ff @(posedge clk) begin
    if (reset) begin
      segMeta_q <= SEG_ALL_OFF;
      segSync_q <= SEG_ALL_OFF;
      selMeta_q <= '0;
      selSync_q <= '0;
    end else begin
      segMeta_q <= segIn;
      segSync_q <= segMeta_q;
      selMeta_q <= selIn;
      selSync_q <= selMeta_q;
    end
  end

  // Stability counter next value: any change restarts at 1, otherwise count up and saturate.
  always_comb begin
    sample        = {selSync_q, segSync_q};
    sampleChanged = (sample != samplePrev_q);
    cnt_d         = cnt_q;
    if (sampleChanged) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_TARGET) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // One-hot detection, index of the selected position and segment decode.
  always_comb begin
    selOneHot = (selSync_q != '0) && ((selSync_q & (selSync_q - 1'b1)) == '0);
    selIdx    = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (selSync_q[i]) begin
        selIdx = 3'(i);
      end
    end
    decoded = decodeSeg(segSync_q);
  end

  // Capture FSM with registered outputs. A commit happens only on the cycle the
  // counter reaches the target while not already LOCKED, so a held pattern is
  // committed exactly once. The errFlag set is written after the clear so an
  // invalid commit wins over a simultaneous clearErr.
  always_ff @(posedge clk) begin
    if (reset) begin
      samplePrev_q   <= {{NUM_DIGITS{1'b0}}, SEG_ALL_OFF};
      cnt_q          <= '0;
      state_q        <= IDLE;
      digits_q       <= '0;
      digitValid_q   <= '0;
      digitBlank_q   <= '0;
      updateStrobe_q <= 1'b0;
      updateIdx_q    <= 3'd0;
      errFlag_q      <= 1'b0;
    end else begin
      samplePrev_q   <= sample;
      cnt_q          <= cnt_d;
      updateStrobe_q <= 1'b0;
      if (clearErr) begin
        errFlag_q <= 1'b0;
      end

      if (!selOneHot) begin
        state_q <= IDLE;
      end else if (sampleChanged) begin
        state_q <= COUNT;
      end else if (state_q != LOCKED) begin
        if (cnt_d == CNT_TARGET) begin
          state_q        <= LOCKED;
          updateStrobe_q <= 1'b1;
          updateIdx_q    <= selIdx;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) == selIdx) begin
              if (decoded[4]) begin
                digits_q[4*i +: 4] <= decoded[3:0];
                digitValid_q[i]    <= 1'b1;
                digitBlank_q[i]    <= 1'b0;
              end else if (segSync_q == SEG_ALL_OFF) begin
                digitValid_q[i]    <= 1'b0;
                digitBlank_q[i]    <= 1'b1;
              end else begin
                digitValid_q[i]    <= 1'b0;
                digitBlank_q[i]    <= 1'b0;
                errFlag_q          <= 1'b1;
              end
            end
          end
        end else begin
          state_q <= COUNT;
        end
      end
    end
  end

  assign digits       = digits_q;
  assign digitValid   = digitValid_q;
  assign digitBlank   = digitBlank_q;
  assign updateStrobe = updateStrobe_q;
  assign updateIdx    = updateIdx_q;
  assign errFlag      = errFlag_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// tb_seg7_capture_decoder
//
// Directed bench for seg7_capture_decoder with NUM_DIGITS=4, STABLE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point, so each tick sees the registers updated by the edge just passed.

module tb_seg7_capture_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  segIn;
  logic [3:0]  selIn;
  logic        clearErr;
  logic [15:0] digits;
  logic [3:0]  digitValid;
  logic [3:0]  digitBlank;
  logic        updateStrobe;
  logic [2:0]  updateIdx;
  logic        errFlag;

  int checks = 0;
  int errors = 0;

  // Strobe log since the last clearLog: cycle counter, number of strobes,
  // cycle of the first strobe and a shift register of strobed indices.
  int          cycleNum;
  int          strobeCount;
  int          firstStrobeAt;
  logic [11:0] idxLog;

  logic [6:0] scanCodes [4];

  seg7_capture_decoder #(
    .NUM_DIGITS   (4),
    .STABLE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .segIn       (segIn),
    .selIn       (selIn),
    .clearErr    (clearErr),
    .digits      (digits),
    .digitValid  (digitValid),
    .digitBlank  (digitBlank),
    .updateStrobe(updateStrobe),
    .updateIdx   (updateIdx),
    .errFlag     (errFlag)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] sel);
    segIn = seg;
    selIn = sel;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearLog();
    cycleNum      = 0;
    strobeCount   = 0;
    firstStrobeAt = -1;
    idxLog        = '0;
  endtask

  task automatic runCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cycleNum++;
      if (updateStrobe === 1'b1) begin
        strobeCount++;
        if (firstStrobeAt < 0) firstStrobeAt = cycleNum;
        idxLog = {idxLog[8:0], updateIdx};
      end
    end
  endtask

  initial begin
    scanCodes[0] = 7'b1111001;
    scanCodes[1] = 7'b0001000;
    scanCodes[2] = 7'b0100001;
    scanCodes[3] = 7'b0001110;

    reset    = 1'b1;
    clearErr = 1'b0;
    applyStimulus(7'b1111111, 4'b0000);
    clearLog();
    runCycles(2);
    checkOutput("reset_digits",  32'(digits),       32'h0);
    checkOutput("reset_valid",   32'(digitValid),   32'h0);
    checkOutput("reset_blank",   32'(digitBlank),   32'h0);
    checkOutput("reset_strobe",  32'(updateStrobe), 32'h0);
    checkOutput("reset_idx",     32'(updateIdx),    32'h0);
    checkOutput("reset_err",     32'(errFlag),      32'h0);

    // Single digit '2' at position 0, held 26 cycles.
    applyStimulus(7'b0100100, 4'b0001);
    reset = 1'b0;
    clearLog();
    runCycles(26);
    checkOutput("s1_strobe_at",    32'(firstStrobeAt), 32'd6);
    checkOutput("s1_strobe_count", 32'(strobeCount),   32'd1);
    checkOutput("s1_digit0",       32'(digits[3:0]),   32'h2);
    checkOutput("s1_valid",        32'(digitValid),    32'b0001);
    checkOutput("s1_idx",          32'(updateIdx),     32'd0);
    checkOutput("s1_err",          32'(errFlag),       32'h0);

    // Scan positions 0..3 with 1, A, d, F.
    clearLog();
    for (int p = 0; p < 4; p++) begin
      applyStimulus(scanCodes[p], 4'(1 << p));
      runCycles(8);
    end
    checkOutput("s2_strobe_count", 32'(strobeCount), 32'd4);
    checkOutput("s2_idx_seq",      32'(idxLog),      32'h053);
    checkOutput("s2_digits",       32'(digits),      32'hFDA1);
    checkOutput("s2_valid",        32'(digitValid),  32'hF);

    // Glitching segments at position 1: 8,6,8,6 every 3 cycles, then 8 held.
    clearLog();
    for (int t = 0; t < 4; t++) begin
      applyStimulus((t % 2 == 0) ? 7'b0000000 : 7'b0000010, 4'b0010);
      runCycles(3);
    end
    checkOutput("s3_glitch_no_strobe", 32'(strobeCount), 32'd0);
    applyStimulus(7'b0000000, 4'b0010);
    clearLog();
    runCycles(10);
    checkOutput("s3_strobe_at",    32'(firstStrobeAt), 32'd6);
    checkOutput("s3_strobe_count", 32'(strobeCount),   32'd1);
    checkOutput("s3_digits",       32'(digits),        32'hFD81);
    checkOutput("s3_idx",          32'(updateIdx),     32'd1);

    // Invalid pattern at position 2.
    clearLog();
    applyStimulus(7'b0111111, 4'b0100);
    runCycles(8);
    checkOutput("s4_err",          32'(errFlag),     32'h1);
    checkOutput("s4_valid",        32'(digitValid),  32'b1011);
    checkOutput("s4_blank",        32'(digitBlank),  32'b0000);
    checkOutput("s4_digits",       32'(digits),      32'hFD81);
    checkOutput("s4_strobe_count", 32'(strobeCount), 32'd1);
    checkOutput("s4_idx",          32'(updateIdx),   32'd2);
    clearErr = 1'b1;
    runCycles(1);
    clearErr = 1'b0;
    checkOutput("s4_err_cleared", 32'(errFlag), 32'h0);
    // Second invalid commit with clearErr on the commit edge: set wins.
    clearLog();
    applyStimulus(7'b0110110, 4'b0100);
    runCycles(5);
    checkOutput("s4_err_before_commit", 32'(errFlag),     32'h0);
    checkOutput("s4_no_early_strobe",   32'(strobeCount), 32'd0);
    clearErr = 1'b1;
    runCycles(1);
    clearErr = 1'b0;
    checkOutput("s4_strobe_at_set_clear", 32'(firstStrobeAt), 32'd6);
    checkOutput("s4_set_wins",            32'(errFlag),       32'h1);

    // Blank at position 3, then two selects at once.
    clearErr = 1'b1;
    runCycles(1);
    clearErr = 1'b0;
    clearLog();
    applyStimulus(7'b1111111, 4'b1000);
    runCycles(8);
    checkOutput("s5_blank",        32'(digitBlank),  32'b1000);
    checkOutput("s5_valid",        32'(digitValid),  32'b0011);
    checkOutput("s5_digits",       32'(digits),      32'hFD81);
    checkOutput("s5_idx",          32'(updateIdx),   32'd3);
    checkOutput("s5_strobe_count", 32'(strobeCount), 32'd1);
    checkOutput("s5_err",          32'(errFlag),     32'h0);
    clearLog();
    applyStimulus(7'b0000000, 4'b0011);
    runCycles(12);
    checkOutput("s5_multisel_no_strobe", 32'(strobeCount), 32'd0);
    checkOutput("s5_multisel_no_err",    32'(errFlag),     32'h0);
    checkOutput("s5_idx_held",           32'(updateIdx),   32'd3);
    checkOutput("s5_valid_held",         32'(digitValid),  32'b0011);

    // Reset in the middle of counting.
    clearLog();
    applyStimulus(7'b0100100, 4'b0001);
    runCycles(3);
    reset = 1'b1;
    runCycles(1);
    checkOutput("s6_digits",    32'(digits),       32'h0);
    checkOutput("s6_valid",     32'(digitValid),   32'h0);
    checkOutput("s6_blank",     32'(digitBlank),   32'h0);
    checkOutput("s6_idx",       32'(updateIdx),    32'h0);
    checkOutput("s6_strobe",    32'(updateStrobe), 32'h0);
    checkOutput("s6_no_strobe", 32'(strobeCount),  32'd0);
    runCycles(1);
    reset = 1'b0;
    clearLog();
    runCycles(10);
    checkOutput("s6_strobe_at",    32'(firstStrobeAt), 32'd6);
    checkOutput("s6_strobe_count", 32'(strobeCount),   32'd1);
    checkOutput("s6_digits_after", 32'(digits),        32'h0002);
    checkOutput("s6_valid_after",  32'(digitValid),    32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
